// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control inputs, instruction-memory port and IF/ID pipeline register outputs.
// The master modport is the fetch stage itself; the slave modport is its environment.
interface fetch_stage_if;
    logic        freeze;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    modport master (
        input  freeze, flush, branch_taken, branch_addr, instr_data,
        output instr_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count
    );

    modport slave (
        output freeze, flush, branch_taken, branch_addr, instr_data,
        input  instr_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall handling and the IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds a counter of valid instructions loaded into IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] pc_next_c;
    logic            if_id_load_c;
    logic            if_id_bubble_c;

    logic [XLEN-1:0] if_id_pc_q;
    logic [XLEN-1:0] if_id_instr_q;
    logic            if_id_valid_q;

    assign pc_plus4_c     = pc_q + XLEN'(4);
    assign bus.instr_addr = {pc_q[XLEN-1:2], 2'b00};

    // Redirect beats stall; otherwise advance sequentially (wraps naturally at 2^32).
    always_comb begin
        pc_next_c = pc_plus4_c;
        if (bus.branch_taken) begin
            pc_next_c = {bus.branch_addr[XLEN-1:2], 2'b00};
        end else if (bus.freeze) begin
            pc_next_c = pc_q;
        end
    end

    // A word fetched in a redirect cycle is on the wrong path, so it is squashed too.
    assign if_id_bubble_c = bus.flush | bus.branch_taken;
    assign if_id_load_c   = !if_id_bubble_c && !bus.freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            pc_q <= pc_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || if_id_bubble_c) begin
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
        end else if (if_id_load_c) begin
            if_id_pc_q    <= pc_plus4_c;
            if_id_instr_q <= bus.instr_data;
            if_id_valid_q <= 1'b1;
        end
    end

    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else if (if_id_load_c) begin
            fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
`else
    assign bus.fetch_count = '0;
`endif
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (word aligned).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port freeze  input  1  hazard stall; hold PC and IF/ID contents.
REQ-005 The block SHALL have port flush  input  1  squash the IF/ID contents (insert bubble).
REQ-006 The block SHALL have port branch_taken  input  1  redirect the PC to branch_addr.
REQ-007 The block SHALL have port branch_addr  input  32  redirect target byte address.
REQ-008 The block SHALL have port instr_addr  output  32  byte address to instruction memory, equal to the current PC.
REQ-009 The block SHALL have port instr_data  input  32  instruction word returned combinationally by instruction memory for instr_addr.
REQ-010 The block SHALL have port if_id_pc  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-011 The block SHALL have port if_id_instr  output  32  registered instruction word for decode.
REQ-012 The block SHALL have port if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-013 The block SHALL have port fetch_count  output  32  count of valid instructions loaded into IF/ID (see Configuration).

Function
REQ-014 The block SHALL drive instr_addr combinationally from the PC register, with bits [1:0] always 0.
REQ-015 The block SHALL compute next PC as: branch_taken -> {branch_addr[31:2],2'b00}; else freeze -> hold; else PC+4 (32-bit, 32'hFFFF_FFFC wraps to 0).
REQ-016 The block SHALL give branch_taken priority over freeze for the PC update.
REQ-017 The block SHALL update IF/ID in priority order: flush or branch_taken -> bubble; else freeze -> hold; else load instr_data, PC+4, valid=1.
REQ-018 The block SHALL define a bubble as if_id_instr=32'h0 (NOP), if_id_pc=32'h0, if_id_valid=0.
REQ-019 The block SHALL have one-cycle latency: the instruction at PC appears on if_id_instr the cycle after PC is presented.
REQ-020 The block SHALL, under flush with freeze and no branch_taken, bubble IF/ID and hold the PC.
REQ-021 The block SHALL never pass an instruction fetched on a branch_taken cycle to IF/ID.

Reset
REQ-022 The block SHALL, while rst=1 at a rising edge, load PC=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, fetch_count=0, overriding all other inputs.
REQ-023 The block SHALL resume normal fetch at RESET_PC on the first edge with rst=0; reset mid-operation discards any pending branch.

Configuration
REQ-024 The block SHALL, with macro FETCH_PERF_CNT_EN defined, increment fetch_count by 1 (wrapping at 2^32) on every edge that loads a valid instruction into IF/ID.
REQ-025 The block SHALL, without FETCH_PERF_CNT_EN, drive fetch_count constant 32'h0 and contain no counter register.

Verification
REQ-026 Reset then 3 free cycles, memory word n = n -> instr_addr 0,4,8,12; if_id_instr 0,1,2; if_id_pc 4,8,12; valid 1.
REQ-027 freeze=1 for 2 cycles at PC=8 -> instr_addr stays 8, IF/ID holds instr 1/pc 8; resumes at 12 after release.
REQ-028 branch_taken=1, branch_addr=32'h0000_0043 at PC=12 -> next instr_addr=32'h40, IF/ID bubble (instr 0, valid 0) that cycle.
REQ-029 branch_taken=1 and freeze=1 together, branch_addr=32'h20 -> PC=32'h20 next edge, IF/ID bubble.
REQ-030 RESET_PC=32'hFFFF_FFFC, 2 free cycles -> instr_addr FFFF_FFFC then 0; if_id_pc=0 for first fetched word.
REQ-031 With FETCH_PERF_CNT_EN: 5 fetches, 1 flush, 2 frozen cycles -> fetch_count=5 (without macro: 0); rst mid-run -> 0.
